pong_score_fsm: RTL



---
 rtl/pong_pkg.sv | 27 ++
 rtl/pong_score_fsm_bcd_counter2.sv | 32 +++
 rtl/pong_score_fsm.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong game-control stage.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SERVE,
    ST_PLAY,
    ST_POINT,
    ST_OVER,
    ST_PAUSE
  } game_state_e;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_P     = 8'h13;

  // Binary 0..99 to two-digit BCD {tens, ones}.
  function automatic logic [7:0] bin2bcd8(input logic [6:0] bin);
    int unsigned v;
    v = int'(bin);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/pong_score_fsm_bcd_counter2.sv
// Two-digit BCD counter with synchronous clear and increment; clear wins.
module bcd_counter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic [7:0] q_o
);

  logic [3:0] ones_q;
  logic [3:0] tens_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_q <= 4'd0;
      tens_q <= 4'd0;
    end else if (clr_i) begin
      ones_q <= 4'd0;
      tens_q <= 4'd0;
    end else if (inc_i) begin
      if (ones_q == 4'd9) begin
        ones_q <= 4'd0;
        tens_q <= (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
      end else begin
        ones_q <= ones_q + 4'd1;
      end
    end
  end

  assign q_o = {tens_q, ones_q};

endmodule

// File: rtl/pong_score_fsm.sv
// Pong game control: frame-synchronous goal detection, BCD scoring, serve/play/over sequencing.
// Optional pause support (P key toggles PLAY/PAUSE) is built when PONG_PAUSE_EN is defined.
module pong_score_fsm
  import pong_pkg::*;
#(
  parameter int         LEFT_GOAL_X  = 0,
  parameter int         RIGHT_GOAL_X = 639,
  parameter int         WIN_SCORE    = 11,
  parameter int         SERVE_FRAMES = 60,
  parameter logic [7:0] START_KEY    = KEY_SPACE
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_vs,
  input  logic [7:0] keycode,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  input  logic [9:0] BallS,
  output logic       ball_run,
  output logic       ball_serve,
  output logic       serve_dir,
  output logic [7:0] score_left,
  output logic [7:0] score_right,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam logic [7:0] WIN_BCD = bin2bcd8(7'(WIN_SCORE));

  game_state_e state_q, state_d;
  logic        vs_s1_q, vs_s2_q, vs_s3_q;
  logic [7:0]  key_q;
  logic [7:0]  serve_cnt_q, serve_cnt_d;
  logic        ball_serve_q, ball_serve_d;
  logic        serve_dir_q, serve_dir_d;
  logic [1:0]  winner_q, winner_d;
  logic        point_left_q, point_left_d;
  logic        frame_tick, start_press;
  logic        left_goal, right_goal;
  logic        inc_left, inc_right, clr_scores;
  logic [10:0] ball_x_ext;
  logic        unused_bally;

  assign unused_bally = ^BallY;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      vs_s1_q      <= 1'b0;
      vs_s2_q      <= 1'b0;
      vs_s3_q      <= 1'b0;
      key_q        <= 8'h00;
      serve_cnt_q  <= 8'd0;
      ball_serve_q <= 1'b0;
      serve_dir_q  <= 1'b0;
      winner_q     <= WIN_NONE;
      point_left_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vs_s1_q      <= frame_vs;
      vs_s2_q      <= vs_s1_q;
      vs_s3_q      <= vs_s2_q;
      key_q        <= keycode;
      serve_cnt_q  <= serve_cnt_d;
      ball_serve_q <= ball_serve_d;
      serve_dir_q  <= serve_dir_d;
      winner_q     <= winner_d;
      point_left_q <= point_left_d;
    end
  end

  assign frame_tick  = vs_s2_q & ~vs_s3_q;
  assign start_press = (keycode == START_KEY) && (key_q != START_KEY);

  // Left test adds BallS to the limit rather than subtracting it from BallX to avoid underflow.
  assign ball_x_ext = {1'b0, BallX};
  assign left_goal  = ball_x_ext <= (11'(LEFT_GOAL_X) + {1'b0, BallS});
  assign right_goal = (ball_x_ext + {1'b0, BallS}) >= 11'(RIGHT_GOAL_X);

`ifdef PONG_PAUSE_EN
  localparam logic [7:0] PAUSE_KEY = KEY_P;
  logic p_press;
  assign p_press = (keycode == PAUSE_KEY) && (key_q != PAUSE_KEY);
`endif

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    serve_cnt_d  = serve_cnt_q;
    ball_serve_d = 1'b0;
    serve_dir_d  = serve_dir_q;
    winner_d     = winner_q;
    point_left_d = point_left_q;
    inc_left     = 1'b0;
    inc_right    = 1'b0;
    clr_scores   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_press) begin
          state_d      = ST_SERVE;
          ball_serve_d = 1'b1;
          serve_dir_d  = 1'b1;
          serve_cnt_d  = 8'd0;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          if (serve_cnt_q == 8'(SERVE_FRAMES - 1)) begin
            state_d     = ST_PLAY;
            serve_cnt_d = 8'd0;
          end else begin
            serve_cnt_d = serve_cnt_q + 8'd1;
          end
        end
      end
      ST_PLAY: begin
`ifdef PONG_PAUSE_EN
        if (p_press) begin
          state_d = ST_PAUSE;
        end else
`endif
        if (frame_tick && left_goal) begin
          state_d      = ST_POINT;
          inc_right    = 1'b1;
          serve_dir_d  = 1'b0;
          point_left_d = 1'b0;
        end else if (frame_tick && right_goal) begin
          state_d      = ST_POINT;
          inc_left     = 1'b1;
          serve_dir_d  = 1'b1;
          point_left_d = 1'b1;
        end
      end
      // Score was bumped on entry, so the registered value is the new score.
      ST_POINT: begin
        if ((point_left_q ? score_left : score_right) == WIN_BCD) begin
          state_d  = ST_OVER;
          winner_d = point_left_q ? WIN_LEFT : WIN_RIGHT;
        end else begin
          state_d      = ST_SERVE;
          ball_serve_d = 1'b1;
          serve_cnt_d  = 8'd0;
        end
      end
      ST_OVER: begin
        if (start_press) begin
          state_d      = ST_SERVE;
          clr_scores   = 1'b1;
          winner_d     = WIN_NONE;
          ball_serve_d = 1'b1;
          serve_dir_d  = 1'b1;
          serve_cnt_d  = 8'd0;
        end
      end
`ifdef PONG_PAUSE_EN
      ST_PAUSE: begin
        if (p_press) state_d = ST_PLAY;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  bcd_counter2 u_score_left (
    .clk  (Clk),
    .rst  (Reset),
    .clr_i(clr_scores),
    .inc_i(inc_left),
    .q_o  (score_left)
  );

  bcd_counter2 u_score_right (
    .clk  (Clk),
    .rst  (Reset),
    .clr_i(clr_scores),
    .inc_i(inc_right),
    .q_o  (score_right)
  );

  assign ball_run   = (state_q == ST_PLAY);
  assign game_over  = (state_q == ST_OVER);
  assign ball_serve = ball_serve_q;
  assign serve_dir  = serve_dir_q;
  assign winner     = winner_q;

endmodule
